fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Small in-order FIFO between the IF stage and the ID stage of the LC-3b
//  pipeline. Buffers {pc, instruction} pairs returned by port-A instruction fetch.
//  Decode stalls therefore do not cancel an in-flight fetch.
//  Back-pressures fetch via 'full'; a taken branch/jump squashes all entries via 'flush'.
// PARAMETERS
//  DEPTH  4  number of entries; power of two, >= 2
// PORTS
//  clk          in   1                 rising-edge clock
//  reset        in   1                 synchronous, active-high
//  flush        in   1                 squash all entries (redirect from EX/MEM)
//  enq_valid    in   1                 fetch has a word this cycle (memory resp_a)
//  enq_pc       in   16 (lc3b_word)    PC of the fetched word
//  enq_instr    in   16 (lc3b_word)    fetched instruction (rdata_a)
//  full         out  1                 queue cannot accept; drives fetch stall
//  deq_ready    in   1                 decode consumes head this cycle
//  deq_valid    out  1                 head entry present
//  deq_pc       out  16 (lc3b_word)    PC of head entry
//  deq_instr    out  16 (lc3b_word)    head instruction; LC3B_NOP when empty
//  count        out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
//  - State: storage[DEPTH], head ptr, tail ptr (log2 DEPTH bits each), count.
//    full  = (count == DEPTH); deq_valid = (count != 0). Both decode from registers only.
//  - enq fires when enq_valid && !full. It writes the entry at tail, and tail = tail+1 mod DEPTH.
//    When full, enq_valid is ignored: no write and no error. Fetch is already stalled by 'full'.
//  - deq fires when deq_ready && deq_valid. head = head+1 mod DEPTH.
//    deq_ready while empty is a no-op.
//  - Simultaneous enq+deq: count unchanged, both pointers advance.
//    Enq is still blocked when full, even with deq in the same cycle. There is no full-bypass.
//  - Latency: a word enqueued at edge N is visible on deq_* after edge N; 1 cycle minimum.
//    There is no combinational enq->deq path.
//  - deq_pc/deq_instr read storage[head] combinationally.
//    When empty: deq_instr = LC3B_NOP (16'h0000, BR never) and deq_pc = 16'h0000.
//  - Pointer wrap: DEPTH-1 -> 0, using natural modulo on log2 DEPTH bits.
//  - flush: at next edge head = tail = count = 0. Any enq or deq in that cycle is discarded.
//    Storage contents are not cleared; they are masked by count.
//  - Priority: reset > flush > enq/deq.
//  - reset: head = tail = count = 0, storage cleared to LC3B_NOP.
//    Outputs after reset: full=0, deq_valid=0, deq_instr=16'h0000, deq_pc=16'h0000, count=0.
//    Reset mid-operation drops all entries exactly like flush.
//  - Never overflows or underflows by construction.
//    Bench asserts 0 <= count <= DEPTH and count == (tail-head) mod DEPTH, except when count == DEPTH.
// STRUCTURE
//  - lc3b_types package: lc3b_word (existing).
//    Add: LC3B_NOP = 16'h0000; typedef struct packed {lc3b_word pc; lc3b_word instr;} lc3b_fq_entry.
//  - Sub-module fq_ptr: wrapping pointer register with clk, reset, clr, inc; instantiated for head and tail.
//  - Storage: lc3b_fq_entry array written in always_ff; occupancy counter in the top module.
// TESTING
//  1 Reset: assert reset 2 cycles -> count=0, full=0, deq_valid=0, deq_instr=16'h0000.
//  2 Fill: DEPTH=4, deq_ready=0, enq 4 words (pc 0x3000..0x3006, instr 0x1021..0x1024).
//    -> full=1 after 4th edge; 5th enq_valid ignored, count=4.
//  3 Drain: then deq_ready=1 for 4 cycles -> deq_instr 0x1021,0x1022,0x1023,0x1024 in order, pcs match.
//    After the last deq, deq_valid=0 and deq_instr=16'h0000.
//  4 Stream/wrap: enq and deq every cycle for 10 cycles after 1 preload.
//    -> count stays 1, output sequence matches input delayed 1 cycle, pointers wrap twice.
//  5 Flush: 3 entries queued, flush=1 with enq_valid=1 and deq_ready=1.
//    -> next cycle count=0, deq_valid=0; the new word is not present.
//  6 Reset mid-stream: count=2, assert reset with enq_valid=1 -> count=0; the next enq appears after 1 cycle.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: machine word, the canonical NOP encoding and
// the {pc, instruction} record buffered between IF and ID.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // BR with no condition bits set never branches, so all-zero decodes as a NOP
    localparam lc3b_word LC3B_NOP = 16'h0000;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word instr;
    } lc3b_fq_entry;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping ring-buffer pointer; wraps DEPTH-1 -> 0 through natural modulo on
// its own width, so DEPTH must be a power of two.
module fq_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_r;

    // Pointer register: reset and clear dominate, then advance on inc
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            ptr_r <= {WIDTH{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fetch_queue.sv
// In-order IF->ID fetch queue. Holds fetched {pc, instr} pairs so a decode
// stall never cancels an in-flight fetch; 'full' back-pressures fetch.
module fetch_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_valid,
    input  logic [15:0]                  enq_pc,
    input  logic [15:0]                  enq_instr,
    output logic                         full,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [15:0]                  deq_pc,
    output logic [15:0]                  deq_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    lc3b_fq_entry       storage_r [DEPTH];
    logic [CW-1:0]      count_r;
    logic [PW-1:0]      head_s;
    logic [PW-1:0]      tail_s;
    logic               full_s;
    logic               deq_valid_s;
    logic               enq_fire_s;
    logic               deq_fire_s;
    lc3b_fq_entry       head_entry_s;

    // Status decodes purely from the occupancy register; no enq->deq bypass
    assign full_s      = (count_r == CW'(DEPTH));
    assign deq_valid_s = (count_r != {CW{1'b0}});
    assign enq_fire_s  = enq_valid && !full_s;
    assign deq_fire_s  = deq_ready && deq_valid_s;

    fq_ptr #(.WIDTH(PW)) u_head (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (deq_fire_s),
        .ptr   (head_s)
    );

    fq_ptr #(.WIDTH(PW)) u_tail (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (enq_fire_s),
        .ptr   (tail_s)
    );

    // Entry storage: cleared on reset; flush leaves stale data masked by count
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_r[i] <= '{pc: LC3B_NOP, instr: LC3B_NOP};
            end
        end else if (!flush && enq_fire_s) begin
            storage_r[tail_s] <= '{pc: enq_pc, instr: enq_instr};
        end else begin
            storage_r <= storage_r;
        end
    end

    // Occupancy counter: simultaneous enq and deq leave it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Head read port; an empty queue presents a NOP at pc 0
    always_comb begin
        head_entry_s = '{pc: LC3B_NOP, instr: LC3B_NOP};
        if (deq_valid_s) begin
            head_entry_s = storage_r[head_s];
        end else begin
            head_entry_s = '{pc: 16'h0000, instr: LC3B_NOP};
        end
    end

    assign full      = full_s;
    assign deq_valid = deq_valid_s;
    assign deq_pc    = head_entry_s.pc;
    assign deq_instr = head_entry_s.instr;
    assign count     = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4) plus a streaming
// wrap-around sequence.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic [15:0] enq_pc = 16'h0000;
    logic [15:0] enq_instr = 16'h0000;
    logic        full;
    logic        deq_ready = 1'b0;
    logic        deq_valid;
    logic [15:0] deq_pc;
    logic [15:0] deq_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .full      (full),
        .deq_ready (deq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        ev;
        logic [15:0] pc;
        logic [15:0] ins;
        logic        dr;
        logic        e_full;
        logic        e_dv;
        logic [15:0] e_pc;
        logic [15:0] e_ins;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic rst, logic fl, logic ev, logic [15:0] pc,
                                 logic [15:0] ins, logic dr, logic e_full, logic e_dv,
                                 logic [15:0] e_pc, logic [15:0] e_ins, logic [2:0] e_cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.ev = ev; v.pc = pc; v.ins = ins; v.dr = dr;
        v.e_full = e_full; v.e_dv = e_dv; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic e_full, input logic e_dv,
                                 input logic [15:0] e_pc, input logic [15:0] e_ins,
                                 input logic [2:0] e_cnt);
        chk("full", idx, {15'h0000, full}, {15'h0000, e_full});
        chk("deq_valid", idx, {15'h0000, deq_valid}, {15'h0000, e_dv});
        chk("deq_pc", idx, deq_pc, e_pc);
        chk("deq_instr", idx, deq_instr, e_ins);
        chk("count", idx, {13'h0000, count}, {13'h0000, e_cnt});
        chk("count_range", idx, {15'h0000, (count <= 3'd4)}, 16'h0001);
    endtask

    initial begin
        // Reset (with enq/deq asserted to prove reset priority)
        vecs.push_back(mkv(1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
        vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
        // Fill to full, then an ignored fifth enq
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h3000, 16'h1021, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h1021, 3'd1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h3002, 16'h1022, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h1021, 3'd2));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h3004, 16'h1023, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h1021, 3'd3));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h3006, 16'h1024, 1'b0, 1'b1, 1'b1, 16'h3000, 16'h1021, 3'd4));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h3008, 16'h1025, 1'b0, 1'b1, 1'b1, 16'h3000, 16'h1021, 3'd4));
        // Drain in order, then deq on empty is a no-op
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3002, 16'h1022, 3'd3));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3004, 16'h1023, 3'd2));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3006, 16'h1024, 3'd1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
        // Refill, then enq+deq while full: enq is blocked
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h4000, 16'h2001, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h2001, 3'd1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h4002, 16'h2002, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h2001, 3'd2));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h4004, 16'h2003, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h2001, 3'd3));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h4006, 16'h2004, 1'b0, 1'b1, 1'b1, 16'h4000, 16'h2001, 3'd4));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h4008, 16'h2005, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h2002, 3'd3));
        // Flush with 3 queued while enq and deq are both requested
        vecs.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h5000, 16'h3001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h5002, 16'h3002, 1'b0, 1'b0, 1'b1, 16'h5002, 16'h3002, 3'd1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h5004, 16'h3003, 1'b0, 1'b0, 1'b1, 16'h5002, 16'h3002, 3'd2));
        // Reset mid-stream with enq_valid, then next enq appears after one cycle
        vecs.push_back(mkv(1'b1, 1'b0, 1'b1, 16'h5006, 16'h3004, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 16'h5008, 16'h3005, 1'b0, 1'b0, 1'b1, 16'h5008, 16'h3005, 3'd1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            enq_valid = vecs[i].ev;
            enq_pc    = vecs[i].pc;
            enq_instr = vecs[i].ins;
            deq_ready = vecs[i].dr;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_full, vecs[i].e_dv, vecs[i].e_pc,
                          vecs[i].e_ins, vecs[i].e_cnt);
        end

        // Stream: one preload, then enq+deq every cycle for 10 cycles
        reset = 1'b0; flush = 1'b0; deq_ready = 1'b0;
        enq_valid = 1'b1; enq_pc = 16'h6000; enq_instr = 16'h4000;
        @(posedge clk);
        #1;
        check_outputs(100, 1'b0, 1'b1, 16'h6000, 16'h4000, 3'd1);
        for (int k = 1; k <= 10; k++) begin
            chk("stream_pre_instr", k, deq_instr, 16'h4000 + 16'(k - 1));
            enq_valid = 1'b1;
            enq_pc    = 16'h6000 + 16'(2 * k);
            enq_instr = 16'h4000 + 16'(k);
            deq_ready = 1'b1;
            @(posedge clk);
            #1;
            check_outputs(100 + k, 1'b0, 1'b1, 16'h6000 + 16'(2 * k),
                          16'h4000 + 16'(k), 3'd1);
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(200, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        deq_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
